// File: rtl/i2c_eeprom_slave.sv
`timescale 1ns/1ps
// I2C target emulating a 24xx EEPROM with 16-bit word addressing over an internal byte RAM.
module i2c_eeprom_slave #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned MEM_AW   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SCL,
  inout  wire         SDA,
  output logic        wr_pulse,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_byte,
  output logic        busy
);

  localparam int unsigned MEM_DEPTH = 1 << MEM_AW;

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, ADDH, ADDH_ACK, ADDL, ADDL_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
  } state_t;

  logic [7:0] mem [MEM_DEPTH];

  logic       scl_meta_q, scl_sync_q, scl_prev_q;
  logic       sda_meta_q, sda_sync_q, sda_prev_q;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [15:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_pulse_q, wr_pulse_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_byte_q, wr_byte_d;
  logic       mem_we;

  logic       scl_rise, scl_fall, scl_high, start_det, stop_det;
  logic [7:0] byte_in, rd_byte, rd_byte_nxt;
  logic [15:0] ptr_inc;

  // Open-drain pad: only ever pulls low.
  assign SDA = sda_oe_q ? 1'b0 : 1'bz;

  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_byte  = wr_byte_q;
  assign busy     = busy_q;

  assign scl_rise  = scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q & scl_prev_q;
  assign scl_high  = scl_sync_q & scl_prev_q;
  assign start_det = scl_high & sda_prev_q & ~sda_sync_q;
  assign stop_det  = scl_high & ~sda_prev_q & sda_sync_q;
  assign byte_in   = {shift_q[6:0], sda_sync_q};
  assign ptr_inc   = ptr_q + 16'd1;
  assign rd_byte     = mem[ptr_q[MEM_AW-1:0]];
  assign rd_byte_nxt = mem[ptr_inc[MEM_AW-1:0]];

  // Pin synchronizers plus one stage of history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= SCL;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= SDA;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  // Byte RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q[MEM_AW-1:0]] <= byte_in;
  end

  // Protocol FSM: START/STOP override, bits sampled on SCL rise, SDA updated on SCL fall.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_byte_d  = wr_byte_q;
    mem_we     = 1'b0;
    if (start_det) begin
      state_d  = DEV;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = 4'd0;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        DEV, ADDH, ADDL, WDATA: begin
          if (scl_rise && (cnt_q < 4'd8)) begin
            shift_d = byte_in;
            cnt_d   = 4'(cnt_q + 4'd1);
            if ((state_q == WDATA) && (cnt_q == 4'd7)) begin
              mem_we     = 1'b1;
              wr_pulse_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_byte_d  = byte_in;
            end
          end else if (scl_fall && (cnt_q == 4'd8)) begin
            cnt_d = 4'd0;
            case (state_q)
              DEV: begin
                if (shift_q[7:1] != DEV_ADDR) begin
                  state_d = WAIT;
                  busy_d  = 1'b0;
                end else begin
                  state_d  = DEV_ACK;
                  sda_oe_d = 1'b1;
                  busy_d   = 1'b1;
                end
              end
              ADDH: begin
                ptr_d[15:8] = shift_q;
                state_d     = ADDH_ACK;
                sda_oe_d    = 1'b1;
              end
              ADDL: begin
                ptr_d[7:0] = shift_q;
                state_d    = ADDL_ACK;
                sda_oe_d   = 1'b1;
              end
              default: begin
                state_d  = WDATA_ACK;
                sda_oe_d = 1'b1;
              end
            endcase
          end
        end
        DEV_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (shift_q[0]) begin
              state_d  = RDATA;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = ADDH;
              sda_oe_d = 1'b0;
            end
          end
        end
        ADDH_ACK: begin
          if (scl_fall) begin
            state_d  = ADDL;
            sda_oe_d = 1'b0;
          end
        end
        ADDL_ACK: begin
          if (scl_fall) begin
            state_d  = WDATA;
            sda_oe_d = 1'b0;
          end
        end
        WDATA_ACK: begin
          if (scl_fall) begin
            state_d  = WDATA;
            sda_oe_d = 1'b0;
            ptr_d    = ptr_inc;
          end
        end
        RDATA: begin
          if (scl_rise && (cnt_q < 4'd8)) begin
            cnt_d = 4'(cnt_q + 4'd1);
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d  = RDATA_ACK;
              cnt_d    = 4'd0;
              sda_oe_d = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        RDATA_ACK: begin
          // cnt_q marks that the master ACKed on the preceding rise.
          if (scl_rise) begin
            if (sda_sync_q) begin
              state_d = WAIT;
              busy_d  = 1'b0;
            end else begin
              cnt_d = 4'd1;
            end
          end else if (scl_fall && (cnt_q == 4'd1)) begin
            ptr_d    = ptr_inc;
            shift_d  = rd_byte_nxt;
            sda_oe_d = ~rd_byte_nxt[7];
            state_d  = RDATA;
            cnt_d    = 4'd0;
          end
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // FSM and registered output state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'd0;
      ptr_q      <= 16'd0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= 16'd0;
      wr_byte_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_byte_q  <= wr_byte_d;
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
`timescale 1ns/1ps
// Bench for i2c_eeprom_slave: bit-banged I2C master with write/read scoreboards.
module tb_i2c_eeprom_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl;
  logic        m_sda_low;
  wire         sda_bus;
  logic        wr_pulse;
  logic [15:0] wr_addr;
  logic [7:0]  wr_byte;
  logic        busy;

  int          n_total = 0;
  int          n_bad   = 0;
  int          qtr     = 1250;
  logic [23:0] wr_exp_q[$];
  logic [7:0]  rd_exp_q[$];
  logic [7:0]  model_mem [256];
  logic        ack;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_eeprom_slave #(.DEV_ADDR(7'h50), .MEM_AW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SCL      (scl),
    .SDA      (sda_bus),
    .wr_pulse (wr_pulse),
    .wr_addr  (wr_addr),
    .wr_byte  (wr_byte),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic put_bit(input logic b);
    m_sda_low = ~b;
    #(qtr); scl = 1'b1;
    #(qtr);
    #(qtr); scl = 1'b0;
    #(qtr);
  endtask

  task automatic get_bit(input logic b, output logic s);
    m_sda_low = ~b;
    #(qtr); scl = 1'b1;
    #(qtr); s = sda_bus;
    #(qtr); scl = 1'b0;
    #(qtr);
  endtask

  task automatic i2c_start;
    m_sda_low = 1'b0;
    #(qtr); scl = 1'b1;
    #(qtr); m_sda_low = 1'b1;
    #(qtr); scl = 1'b0;
    #(qtr);
  endtask

  task automatic i2c_stop;
    m_sda_low = 1'b1;
    #(qtr); scl = 1'b1;
    #(qtr); m_sda_low = 1'b0;
    #(qtr);
    #(qtr);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(1'b1, a);
  endtask

  task automatic exp_write(input logic [15:0] a, input logic [7:0] d);
    wr_exp_q.push_back({a, d});
    model_mem[a[7:0]] = d;
  endtask

  task automatic read_and_check(input logic [15:0] a, input logic mack, input string tag);
    logic [7:0] d;
    logic       s;
    logic       slot;
    rd_exp_q.push_back(model_mem[a[7:0]]);
    for (int i = 7; i >= 0; i--) begin
      get_bit(1'b1, s);
      d[i] = s;
    end
    get_bit(mack, slot);
    chk(tag, 32'(d), 32'(rd_exp_q.pop_front()));
    if (mack) chk({tag, "_nack_slot"}, 32'(slot), 32'd1);
  endtask

  task automatic addr_phase(input logic [15:0] a, input string tag);
    logic x;
    send_byte(8'hA0, x);  chk({tag, "_ack_dev"}, 32'(x), 32'd0);
    send_byte(a[15:8], x); chk({tag, "_ack_ah"}, 32'(x), 32'd0);
    send_byte(a[7:0], x);  chk({tag, "_ack_al"}, 32'(x), 32'd0);
  endtask

  // Write scoreboard: every committed byte must match the oldest expectation.
  always @(posedge clk) begin
    logic [31:0] exp32;
    #1;
    if (rst_n === 1'b1 && wr_pulse === 1'b1) begin
      exp32 = (wr_exp_q.size() != 0) ? 32'(wr_exp_q.pop_front()) : 32'hDEAD_BEEF;
      chk("wr_commit", {8'h00, wr_addr, wr_byte}, exp32);
    end
  end

  // Time bound for the whole run.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; scl = 1'b1; m_sda_low = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    chk("rst_wr_addr",  32'(wr_addr),  32'd0);
    chk("rst_wr_byte",  32'(wr_byte),  32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_sda",      32'(sda_bus),  32'd1);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Byte write at 200 kHz.
    qtr = 1250;
    i2c_start;
    send_byte(8'hA0, ack); chk("bw_ack_dev", 32'(ack), 32'd0);
    chk("bw_busy_set", 32'(busy), 32'd1);
    send_byte(8'h00, ack); chk("bw_ack_ah", 32'(ack), 32'd0);
    send_byte(8'h12, ack); chk("bw_ack_al", 32'(ack), 32'd0);
    exp_write(16'h0012, 8'h5A);
    send_byte(8'h5A, ack); chk("bw_ack_data", 32'(ack), 32'd0);
    i2c_stop;
    chk("bw_busy_clr", 32'(busy), 32'd0);
    chk("bw_left", 32'(wr_exp_q.size()), 32'd0);

    // Random read at 400 kHz.
    qtr = 625;
    i2c_start;
    addr_phase(16'h0012, "rr");
    i2c_start;
    send_byte(8'hA1, ack); chk("rr_ack_rd", 32'(ack), 32'd0);
    read_and_check(16'h0012, 1'b1, "rr_data");
    chk("rr_busy_clr", 32'(busy), 32'd0);
    i2c_stop;

    // Address mismatch: no ACK, target parks until STOP.
    i2c_start;
    send_byte(8'hA2, ack); chk("mm_ack_dev", 32'(ack), 32'd1);
    chk("mm_busy", 32'(busy), 32'd0);
    send_byte(8'h40, ack); chk("mm_ack_wait", 32'(ack), 32'd1);
    i2c_stop;

    // Pointer wrap on write and sequential read.
    i2c_start;
    addr_phase(16'hFFFF, "wr");
    exp_write(16'hFFFF, 8'h11);
    send_byte(8'h11, ack); chk("wr_ack_d0", 32'(ack), 32'd0);
    exp_write(16'h0000, 8'h22);
    send_byte(8'h22, ack); chk("wr_ack_d1", 32'(ack), 32'd0);
    i2c_stop;
    chk("wrap_left", 32'(wr_exp_q.size()), 32'd0);
    i2c_start;
    addr_phase(16'hFFFF, "sr");
    i2c_start;
    send_byte(8'hA1, ack); chk("sr_ack_rd", 32'(ack), 32'd0);
    read_and_check(16'hFFFF, 1'b0, "sr_data0");
    read_and_check(16'h0000, 1'b1, "sr_data1");
    chk("sr_busy_clr", 32'(busy), 32'd0);
    i2c_stop;

    // Abort: partial data byte dropped by repeated START.
    i2c_start;
    addr_phase(16'h0030, "ab");
    exp_write(16'h0030, 8'h77);
    send_byte(8'h77, ack); chk("ab_ack_data", 32'(ack), 32'd0);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    i2c_start;
    send_byte(8'hA0, ack); chk("ab_ack_new", 32'(ack), 32'd0);

    // Reset while the target holds SDA low in the device ACK slot.
    i2c_start;
    for (int i = 7; i >= 0; i--) put_bit(1'(8'hA0 >> i));
    m_sda_low = 1'b0;
    chk("ab_ack_held", 32'(sda_bus), 32'd0);
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    chk("ar_sda",      32'(sda_bus),  32'd1);
    chk("ar_wr_pulse", 32'(wr_pulse), 32'd0);
    chk("ar_wr_addr",  32'(wr_addr),  32'd0);
    chk("ar_wr_byte",  32'(wr_byte),  32'd0);
    chk("ar_busy",     32'(busy),     32'd0);
    #200 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    i2c_stop;
    repeat (10) @(posedge clk);
    chk("final_left", 32'(wr_exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
I2C responder that emulates a 24xx-style EEPROM with 16-bit word addressing, backed by an internal byte RAM. It oversamples SCL/SDA on the system clock, detects START/STOP, matches the device address and ACKs each byte. It supports byte/page write, random read and sequential read. It is the bus-side counterpart of the EEPROM write/read controller, used as an on-chip target for loopback and as a simulation model.

Parameters:
DEV_ADDR, 7'h50, 7-bit device address (write byte 0xA0, read byte 0xA1)
MEM_AW, 8, RAM depth 2^MEM_AW bytes; RAM is indexed by ptr[MEM_AW-1:0]

Ports:
clk  input  1  system clock (50 MHz nominal)
rst_n  input  1  asynchronous active-low reset
SCL  input  1  I2C clock from master
SDA  inout  1  I2C data; open-drain: driven 0 or released to z, never driven 1
wr_pulse  output  1  one-clk pulse when a write data byte is committed to RAM
wr_addr  output  16  full pointer value of the committed byte
wr_byte  output  8  committed data byte
busy  output  1  high from a matched device byte's ACK until STOP, NACK or mismatch

Behaviour:
- Reset: wr_pulse=0, wr_addr=0, wr_byte=0, busy=0, SDA released, ptr=0, state IDLE. RAM contents are not reset. Reset mid-transfer releases SDA immediately (async).
- SCL and SDA pass through 2-FF synchronizers. Edges are detected on the synced signals (1 further register).
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while SCL is high. Both are checked in every state and override everything else.
- START (including repeated START, including mid-byte) -> DEV, bit counter=0, SDA released. STOP -> IDLE, busy=0, SDA released.
- Data sampling: receive bits are shifted MSB first on SCL rising edges. SDA output changes only on SCL falling edges.
- ACK slot: after the 8th rising edge, at the next falling edge pull SDA low. At the following falling edge release SDA, or drive the first read bit.
- States: IDLE, DEV, DEV_ACK, ADDH, ADDH_ACK, ADDL, ADDL_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
- DEV: 8 bits received.
  - If byte[7:1]!=DEV_ADDR -> WAIT: no ACK, busy=0.
  - If it matches and R/W=0 -> DEV_ACK -> ADDH.
  - If it matches and R/W=1 -> DEV_ACK -> RDATA.
  - busy is set at the ACK falling edge.
- ADDH / ADDL: 8 bits each, each ACKed. ptr[15:8]=ADDH, ptr[7:0]=ADDL. After ADDL_ACK -> WDATA.
- WDATA:
  - On the 8th rising edge: RAM[ptr]<=byte; wr_pulse=1 for one clk with wr_addr=ptr, wr_byte=byte.
  - Then ACK (WDATA_ACK), ptr<=ptr+1 (16-bit wrap, 0xFFFF -> 0x0000), back to WDATA.
  - Writes are unbounded; there is no page limit.
  - A partial byte followed by STOP/START is discarded.
- RDATA:
  - The shift register loads RAM[ptr] at the falling edge that ends the preceding ACK. Bits are driven MSB first; a 1 bit releases SDA.
  - After the 8th bit, SDA is released at the falling edge and RDATA_ACK samples the master bit on the rising edge.
  - Master bit 0 (ACK): ptr+1 (wrap), reload, stay in RDATA.
  - Master bit 1 (NACK): -> WAIT, busy=0.
- WAIT: SDA released; leave only on START or STOP.
- Read immediately after a write-address phase without data (random read): the repeated START in ADDL_ACK/WDATA -> DEV with ptr preserved.
- Timing: the block tolerates SCL up to 400 kHz at 50 MHz clk. Worst-case response from pin edge to SDA drive is 4 clk.

Test Plan:
- Byte write: START, 0xA0, 0x00, 0x12, 0x5A, STOP at 200 kHz -> SDA low in all 4 ACK slots; exactly one wr_pulse with wr_addr=0x0012, wr_byte=0x5A; busy 0 after STOP.
- Random read: preload as above, then START A0 00 12, Sr A1, clock 8 bits, master NACK, STOP -> slave drives 0x5A MSB first; SDA released in the NACK slot; busy=0.
- Address mismatch: START, 0xA2, … -> SDA stays z in the ACK slot (master reads 1); no wr_pulse; state WAIT until STOP.
- Wrap: write address 0xFFFF, data 0x11, 0x22 -> wr_pulse twice: (0xFFFF, 0x11) then (0x0000, 0x22); sequential read from 0xFFFF with master ACK returns 0x11, 0x22.
- Abort: repeated START after 4 bits of WDATA -> no wr_pulse, slave ACKs the new 0xA0. Then drive rst_n low during DEV_ACK -> SDA z within the same clk, all outputs at reset values.
